// File: rtl/dff_write_arbiter_if.sv
// Request/grant bus between requester blocks and the shared write-arbitrated register.
// Requesters use the master modport; the arbiter uses the slave modport.
interface dff_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       gnt;
    logic                  gnt_valid;
    logic [2:0]            owner;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qn;

    modport master (
        output req, lock, din,
        input  gnt, gnt_valid, owner, q, qn
    );

    modport slave (
        input  req, lock, din,
        output gnt, gnt_valid, owner, q, qn
    );
endinterface

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of a shared WIDTH-bit q/qn register, with bounded lock.
// Define DFF_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module dff_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    dff_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [3:0]        hold_q, hold_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [2:0]        owner_q, owner_d;
    logic [WIDTH-1:0]  q_q, q_d;

    logic              found_s;
    logic [2:0]        win_s;
    logic              req_own_s;
    logic              lock_own_s;
    logic              lock_cont_s;
    logic              in_grant_s;

    function automatic logic [WIDTH-1:0] sel_data(input logic [NREQ*WIDTH-1:0] d,
                                                  input logic [2:0] s);
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == s) begin
                r = d[i*WIDTH +: WIDTH];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [2:0] s);
        logic [NREQ-1:0] r;
        r = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            r[i] = (3'(i) == s);
        end
        return r;
    endfunction

    // Winner search: circular from ptr (two passes), or plain lowest-index when fixed priority.
    always_comb begin
        found_s = 1'b0;
        win_s   = 3'd0;
`ifndef DFF_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && bus.req[i] && (3'(i) >= ptr_q)) begin
                found_s = 1'b1;
                win_s   = 3'(i);
            end else begin
                found_s = found_s;
            end
        end
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && bus.req[i]) begin
                found_s = 1'b1;
                win_s   = 3'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Current owner's req/lock bits and whether its lock may continue this edge.
    always_comb begin
        req_own_s  = 1'b0;
        lock_own_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == owner_q) begin
                req_own_s  = bus.req[i];
                lock_own_s = bus.lock[i];
            end else begin
                req_own_s  = req_own_s;
            end
        end
        case (state_q)
            ST_GRANT:  in_grant_s = 1'b1;
            ST_LOCKED: in_grant_s = 1'b1;
            default:   in_grant_s = 1'b0;
        endcase
        lock_cont_s = in_grant_s && req_own_s && lock_own_s && (hold_q < 4'(HOLD_MAX));
    end

    // Next-state: lock continuation beats arbitration; no request drops the grant.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        q_d         = q_q;
        if (lock_cont_s) begin
            state_d = ST_LOCKED;
            gnt_d   = onehot(owner_q);
            q_d     = sel_data(bus.din, owner_q);
            hold_d  = hold_q + 4'd1;
        end else if (found_s) begin
            state_d = ST_GRANT;
            gnt_d   = onehot(win_s);
            owner_d = win_s;
            q_d     = sel_data(bus.din, win_s);
            hold_d  = 4'd0;
`ifndef DFF_ARB_FIXED_PRIO_EN
            if (win_s == 3'(NREQ-1)) begin
                ptr_d = 3'd0;
            end else begin
                ptr_d = win_s + 3'd1;
            end
`endif
        end else begin
            state_d = ST_IDLE;
            gnt_d   = {NREQ{1'b0}};
            hold_d  = 4'd0;
        end
        gnt_valid_d = |gnt_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            hold_q      <= 4'd0;
            gnt_q       <= {NREQ{1'b0}};
            gnt_valid_q <= 1'b0;
            owner_q     <= 3'd0;
            q_q         <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            owner_q     <= owner_d;
            q_q         <= q_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.owner     = owner_q;
    assign bus.q         = q_q;
    assign bus.qn        = ~q_q;
endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed self-checking bench for dff_write_arbiter (NREQ=4, WIDTH=8, HOLD_MAX=4).
module tb_dff_write_arbiter;
    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    dff_write_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    dff_write_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_MAX(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;
        bus.din  = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        bus.req  = 4'b1111;
        bus.lock = 4'b0000;
        bus.din  = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        tick();
        n_tests++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.owner !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_gnt: gnt=%b valid=%b owner=%0d, want 0000/0/0",
                     bus.gnt, bus.gnt_valid, bus.owner);
        end
        n_tests++;
        if (bus.q !== 8'h00 || bus.qn !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_q: q=%h qn=%h, want 00/ff", bus.q, bus.qn);
        end
        reset_n = 1'b1;
        tick();
        n_tests++;
        if (bus.gnt !== 4'b0001 || bus.q !== 8'h11 || bus.gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%b q=%h valid=%b, want 0001/11/1",
                     bus.gnt, bus.q, bus.gnt_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [8];
        logic [7:0] exp_q [8];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (bus.gnt !== exp_g[i] || bus.q !== exp_q[i] || bus.qn !== ~exp_q[i]) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: gnt=%b q=%h qn=%h, want %b/%h/%h",
                         i, bus.gnt, bus.q, bus.qn, exp_g[i], exp_q[i], ~exp_q[i]);
            end
        end
    endtask

    task automatic test_sparse_and_idle();
        logic [3:0] exp_g [4];
        logic [7:0] exp_q [4];
        exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        exp_q = '{8'h11, 8'h33, 8'h11, 8'h33};
        do_reset();
        bus.req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (bus.gnt !== exp_g[i] || bus.q !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sparse_cycle%0d: gnt=%b q=%h, want %b/%h",
                         i, bus.gnt, bus.q, exp_g[i], exp_q[i]);
            end
        end
        bus.req = 4'b0000;
        tick();
        n_tests++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.q !== 8'h33 ||
            bus.qn !== 8'hCC || bus.owner !== 3'd2) begin
            n_fail++;
            $display("FAIL idle_hold: gnt=%b valid=%b q=%h qn=%h owner=%0d, want 0000/0/33/cc/2",
                     bus.gnt, bus.gnt_valid, bus.q, bus.qn, bus.owner);
        end
    endtask

    task automatic test_lock();
        logic [3:0] exp_g [7];
        exp_g = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        do_reset();
        bus.req  = 4'b1111;
        bus.lock = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            // Mid-lock data change must reach q while the owner holds the register.
            if (i == 3) bus.din[15:8] = 8'h55;
            tick();
            n_tests++;
            if (bus.gnt !== exp_g[i]) begin
                n_fail++;
                $display("FAIL lock_cycle%0d: gnt=%b, want %b", i, bus.gnt, exp_g[i]);
            end
            if (i == 3) begin
                n_tests++;
                if (bus.q !== 8'h55 || bus.owner !== 3'd1) begin
                    n_fail++;
                    $display("FAIL lock_data: q=%h owner=%0d, want 55/1", bus.q, bus.owner);
                end
            end
        end
        bus.req = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_tests++;
            if (bus.gnt !== 4'b0010 || bus.owner !== 3'd1) begin
                n_fail++;
                $display("FAIL lock_alone_cycle%0d: gnt=%b owner=%0d, want 0010/1",
                         i, bus.gnt, bus.owner);
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        bus.req  = 4'b0100;
        bus.lock = 4'b0100;
        tick();
        tick();
        tick();
        n_tests++;
        if (bus.gnt !== 4'b0100 || bus.q !== 8'h33) begin
            n_fail++;
            $display("FAIL midlock_pre: gnt=%b q=%h, want 0100/33", bus.gnt, bus.q);
        end
        reset_n = 1'b0;
        tick();
        n_tests++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.owner !== 3'd0 ||
            bus.q !== 8'h00 || bus.qn !== 8'hFF) begin
            n_fail++;
            $display("FAIL midlock_reset: gnt=%b valid=%b owner=%0d q=%h qn=%h, want 0000/0/0/00/ff",
                     bus.gnt, bus.gnt_valid, bus.owner, bus.q, bus.qn);
        end
        reset_n = 1'b1;
        tick();
        n_tests++;
        if (bus.gnt !== 4'b0100 || bus.owner !== 3'd2) begin
            n_fail++;
            $display("FAIL midlock_regrant: gnt=%b owner=%0d, want 0100/2", bus.gnt, bus.owner);
        end
        // A fresh hold count allows four more locked cycles before release to requester 1.
        bus.req = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (bus.gnt !== ((i < 4) ? 4'b0100 : 4'b0010)) begin
                n_fail++;
                $display("FAIL midlock_hold%0d: gnt=%b, want %b",
                         i, bus.gnt, ((i < 4) ? 4'b0100 : 4'b0010));
            end
        end
    endtask

    task automatic test_priority_mode();
        logic [3:0] exp_g [4];
`ifdef DFF_ARB_FIXED_PRIO_EN
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
        exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
`endif
        do_reset();
        bus.req = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (bus.gnt !== exp_g[i]) begin
                n_fail++;
                $display("FAIL prio_cycle%0d: gnt=%b, want %b", i, bus.gnt, exp_g[i]);
            end
        end
        bus.req = 4'b0100;
        tick();
        n_tests++;
        if (bus.gnt !== 4'b0100 || bus.q !== 8'h33) begin
            n_fail++;
            $display("FAIL prio_single: gnt=%b q=%h, want 0100/33", bus.gnt, bus.q);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;
        bus.din  = {8'h44, 8'h33, 8'h22, 8'h11};
        test_reset();
        test_round_robin();
        test_sparse_and_idle();
        test_lock();
        test_reset_mid_lock();
        test_priority_mode();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
